// File: rtl/div_unit.sv
// Multicycle signed divider: restoring division, one quotient bit per cycle,
// quotient truncated toward zero, fixed WIDTH+1 cycle start-to-ready latency.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic             r_sign;
    logic             r_zero;
    logic             r_ovf;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_diff;

    // Magnitudes of the most negative value wrap to 2^(W-1), which is the
    // correct unsigned magnitude.
    assign w_abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // One extra bit keeps the compare exact when the divisor is 2^(W-1);
    // w_diff[WIDTH] set means the trial subtraction borrowed.
    assign w_rem_shift = {r_rem, r_q[WIDTH-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_div};

    assign o_dbg_state = r_state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_IDLE;
            S_RUN:   if (r_count == LAST) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // A start pulse restarts from any state.
        if (ctrl_div) w_next = S_RUN;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count        <= '0;
            r_q            <= '0;
            r_rem          <= '0;
            r_div          <= '0;
            r_sign         <= 1'b0;
            r_zero         <= 1'b0;
            r_ovf          <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_div) begin
                r_q     <= w_abs_a;
                r_div   <= w_abs_b;
                r_rem   <= '0;
                r_count <= '0;
                r_sign  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                r_zero  <= (data_operandB == '0);
                r_ovf   <= (data_operandA == MIN_VAL) && (data_operandB == '1);
            end else if (r_state == S_RUN) begin
                r_rem   <= w_diff[WIDTH] ? w_rem_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                r_q     <= {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
                r_count <= r_count + 1'b1;
            end else if (r_state == S_DONE) begin
                data_resultRDY <= 1'b1;
                if (r_zero) begin
                    data_result    <= '0;
                    data_exception <= 1'b1;
                end else if (r_ovf) begin
                    data_result    <= MIN_VAL;
                    data_exception <= 1'b1;
                end else begin
                    data_result    <= r_sign ? -r_q : r_q;
                    data_exception <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vectors with literal expectations, a signed
// arithmetic reference model, and a per-cycle compare process.
module tb_div_unit;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_VAL = 32'h8000_0000;

    logic         clock;
    logic         reset_n;
    logic         ctrl_div;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic [1:0]   o_dbg_state;

    div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .o_dbg_state    (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic         exc_q[$];
    int           cyc_q[$];
    logic [W-1:0] hold_r = '0;
    logic         hold_e = 1'b0;
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain signed division, with the two exception cases.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic signed [W-1:0] q;
        sa = a;
        sb = b;
        if (sb == 0) return {1'b1, {W{1'b0}}};
        if (a == MIN_VAL && sb == -1) return {1'b1, MIN_VAL};
        q = sa / sb;
        return {1'b0, q};
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        if (reset_n) begin
            if (data_resultRDY) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rdy: got rdy=1 expected rdy=0 (cycle %0d)", cyc);
                end else begin
                    logic [W-1:0] er;
                    logic         ee;
                    int           ec;
                    er = exp_q.pop_front();
                    ee = exc_q.pop_front();
                    ec = cyc_q.pop_front();
                    check("rdy_cycle", 32'(cyc), 32'(ec));
                    check("result", data_result, er);
                    check("exception", 32'(data_exception), 32'(ee));
                    hold_r = er;
                    hold_e = ee;
                end
            end else begin
                check("hold_result", data_result, hold_r);
                check("hold_exc", 32'(data_exception), 32'(hold_e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] er, input logic ee);
        @(posedge clock);
        #1;
        ctrl_div      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        // A new start abandons any pending operation.
        exp_q.delete();
        exc_q.delete();
        cyc_q.delete();
        exp_q.push_back(er);
        exc_q.push_back(ee);
        cyc_q.push_back(cyc + 1 + 33);
        @(posedge clock);
        #1;
        ctrl_div      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            #1;
            if (exp_q.size() == 0) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL rdy_timeout: got no rdy expected rdy within 40 cycles (cycle %0d)", cyc);
        exp_q.delete();
        exc_q.delete();
        cyc_q.delete();
    endtask

    task automatic run_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] er, input logic ee);
        logic [W:0] m;
        m = model(a, b);
        check({name, "_model_res"}, m[W-1:0], er);
        check({name, "_model_exc"}, 32'(m[W]), 32'(ee));
        start_op(a, b, er, ee);
        wait_done();
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_result"}, data_result, '0);
        check({name, "_exc"}, 32'(data_exception), 32'(0));
        check({name, "_rdy"}, 32'(data_resultRDY), 32'(0));
        check({name, "_state"}, 32'(o_dbg_state), 32'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n       = 1'b0;
        ctrl_div      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        check_outputs_zero("reset");
        reset_n = 1'b1;

        run_vec("p100_d7",   32'd100,        32'd7,          32'd14,         1'b0);
        run_vec("n100_d7",   -32'sd100,      32'd7,          32'hFFFF_FFF2,  1'b0);
        run_vec("p100_dn7",  32'd100,        -32'sd7,        32'hFFFF_FFF2,  1'b0);
        run_vec("n100_dn7",  -32'sd100,      -32'sd7,        32'd14,         1'b0);
        run_vec("div_zero",  32'd5,          32'd0,          32'd0,          1'b1);
        run_vec("ovf",       32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1);
        run_vec("max_min",   32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);
        run_vec("min_min",   32'h8000_0000,  32'h8000_0000,  32'd1,          1'b0);
        run_vec("zero_9",    32'd0,          32'd9,          32'd0,          1'b0);
        run_vec("three_9",   32'd3,          32'd9,          32'd0,          1'b0);
        run_vec("n7_2",      -32'sd7,        32'd2,          32'hFFFF_FFFD,  1'b0);
        run_vec("zero_zero", 32'd0,          32'd0,          32'd0,          1'b1);
        run_vec("min_1",     32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0);

        // Abort: restart mid-run, only the second operation reports.
        start_op(32'd100, 32'd7, 32'd14, 1'b0);
        repeat (8) @(posedge clock);
        start_op(32'd81, 32'd9, 32'd9, 1'b0);
        wait_done();

        // Reset in the middle of a run: outputs clear at once, no ready follows.
        start_op(32'd100, 32'd7, 32'd14, 1'b0);
        repeat (13) @(posedge clock);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        exc_q.delete();
        cyc_q.delete();
        hold_r = '0;
        hold_e = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (40) @(posedge clock);
        run_vec("after_reset", 32'd8, 32'd2, 32'd4, 1'b0);

        // Random signed regression against the model.
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [W:0]   m;
            case ($urandom_range(0, 3))
                0:       a = $urandom_range(0, 1000);
                1:       a = -$urandom_range(0, 1000);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(1, 20);
                1:       b = -$urandom_range(1, 20);
                default: b = $urandom;
            endcase
            if (b == '0) b = 32'd1;
            if (a == MIN_VAL && b == '1) b = 32'd2;
            m = model(a, b);
            start_op(a, b, m[W-1:0], m[W]);
            wait_done();
        end

        repeat (5) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
